serial_adder: RTL and testbench

Bit-serial N-bit adder: a parameterised word add resolved one bit per clock through a single instance of the team's 1-bit full-adder cell (`fulladder`). It uses one adder cell and a carry flip-flop instead of an N-cell ripple chain. It consumes the cell's `s`/`cary` outputs each cycle, accumulating sum bits in a shift register and feeding `cary` back as the next cycle's carry-in. It is a start/done handshaked unit for area-constrained datapaths.

---
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop resolve one
// bit per clock, LSB first, under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_cary;
  logic             last_s;

  assign last_s = (cnt_q == CW'(WIDTH - 1));

  fulladder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (carry_q),
    .s    (fa_s),
    .cary (fa_cary)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_s ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle, else hold.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          sum_d   = '0;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          a_d = a_q;
        end
      end
      RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_cary;
        cnt_d            = cnt_q + CW'(1);
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// 1-bit full-adder cell shared by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cary
);

  assign s    = a ^ b ^ c;
  assign cary = (a & b) | (c & (a ^ b));

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): scoreboard of expected
// {cout,sum} pushed at each accepted start, popped when done pulses.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  logic [W:0] sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    sb_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [W+2:0] obs;
    obs = {busy, done, cout, sum};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {busy, done, cout, sum};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_basic();
    logic [W:0] exp;
    logic       bad;
    accept(8'h3C, 8'h0F, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      step();
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL basic_busy: busy/done wrong during run, want busy=1 done=0 for %0d cycles", W);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_timing: done=%b busy=%b want done=1 busy=0", done, busy);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({cout, sum} !== exp) begin
      n_bad++;
      $display("FAIL basic_result: got %h want %h", {cout, sum}, exp);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL basic_hold: got %h done=%b want %h done=0", {cout, sum}, done, exp);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta[2] = '{8'hFF, 8'hFF};
    logic [W-1:0] tb[2] = '{8'h01, 8'hFF};
    logic         tc[2] = '{1'b0, 1'b1};
    logic [W:0]   tx[2] = '{9'h100, 9'h1FF};
    logic [W:0]   exp;
    int           cyc;
    for (int i = 0; i < 2; i++) begin
      accept(ta[i], tb[i], tc[i]);
      wait_done(cyc);
      n_cmp++;
      if (cyc != W) begin
        n_bad++;
        $display("FAIL carry_latency[%0d]: got %0d want %0d", i, cyc, W);
      end
      exp = sb_q.pop_front();
      n_cmp++;
      if ({cout, sum} !== exp || exp !== tx[i]) begin
        n_bad++;
        $display("FAIL carry_result[%0d]: got %h want %h", i, {cout, sum}, tx[i]);
      end
      step();
      step();
    end
  endtask

  task automatic test_ignored();
    logic [W:0] exp;
    int         cyc;
    int         dc0;
    logic       bad;
    dc0 = done_cnt;
    accept(8'h12, 8'h34, 1'b0);
    step();
    step();
    start = 1'b1;
    a_in  = 8'h00;
    b_in  = 8'h00;
    cin   = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc != W - 3) begin
      n_bad++;
      $display("FAIL ignored_latency: got %0d want %0d", cyc, W - 3);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({cout, sum} !== 9'h046 || exp !== 9'h046) begin
      n_bad++;
      $display("FAIL ignored_result: got %h want 046", {cout, sum});
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad || done_cnt - dc0 != 1) begin
      n_bad++;
      $display("FAIL ignored_single_op: done pulses %0d want 1, extra busy=%b", done_cnt - dc0, bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [W+2:0] obs;
    logic [W:0]   exp;
    int           cyc;
    int           dc0;
    accept(8'hAA, 8'h55, 1'b0);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    obs = {busy, done, cout, sum};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL resetmid_async: got %h want 0", obs);
    end
    sb_q.delete();
    dc0 = done_cnt;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    obs = {busy, done, cout, sum};
    n_cmp++;
    if (done_cnt != dc0 || obs !== '0) begin
      n_bad++;
      $display("FAIL resetmid_abort: dones %0d outputs %h want 0 and 0", done_cnt - dc0, obs);
    end
    accept(8'h80, 8'h80, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc != W) begin
      n_bad++;
      $display("FAIL resetmid_latency: got %0d want %0d", cyc, W);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({cout, sum} !== exp) begin
      n_bad++;
      $display("FAIL resetmid_result: got %h want %h", {cout, sum}, exp);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    int         c1;
    int         c2;
    a_in  = 8'h01;
    b_in  = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    step();
    sb_q.push_back(9'h002);
    a_in = 8'h7F;
    b_in = 8'h01;
    wait_done(c1);
    sb_q.push_back(9'h080);
    exp = sb_q.pop_front();
    n_cmp++;
    if ({cout, sum} !== exp || c1 != W) begin
      n_bad++;
      $display("FAIL b2b_first: got %h after %0d want %h after %0d", {cout, sum}, c1, exp, W);
    end
    step();
    wait_done(c2);
    start = 1'b0;
    n_cmp++;
    if (c2 + 1 != W + 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d want %0d", c2 + 1, W + 2);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({cout, sum} !== exp) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", {cout, sum}, exp);
    end
    step();
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_basic();
    test_carry();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
